// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, control-bundle layout and helpers for the pipelined MIPS control unit.
// The optional PIPE_CTRL_FORWARD_EN build uses fwd_sel() to pick forwarding sources.
package pipe_ctrl_pkg;

  localparam int OPCODE_W   = 6;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_LH    = 6'h21;
  localparam logic [OPCODE_W-1:0] OP_LHU   = 6'h25;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'd2;

  // Control bundle bit offsets; ALU op occupies ALUOP_W bits from CB_ALU_OP.
  localparam int CB_REG_DST    = 0;
  localparam int CB_ALU_SRC    = 1;
  localparam int CB_ALU_OP     = 2;
  localparam int CB_BRANCH     = 4;
  localparam int CB_BRANCH_NE  = 5;
  localparam int CB_MEM_READ   = 6;
  localparam int CB_MEM_WRITE  = 7;
  localparam int CB_REG_WRITE  = 8;
  localparam int CB_MEM_TO_REG = 9;
  localparam int CB_W          = 10;

  typedef logic [CB_W-1:0]       ctrl_bundle_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    EV_RUN       = 2'd0,
    EV_MEM_STALL = 2'd1,
    EV_FLUSH     = 2'd2,
    EV_HAZARD    = 2'd3
  } pipe_event_t;

  // A dest of 0 means "no write", so register 0 can never match.
  function automatic logic reg_match(input reg_addr_t dest, input reg_addr_t rs,
                                     input reg_addr_t rt);
    return (dest != '0) && ((dest == rs) || (dest == rt));
  endfunction

  function automatic logic [1:0] fwd_sel(input reg_addr_t src, input reg_addr_t ex_dest,
                                         input reg_addr_t mem_dest);
    if (src != '0 && src == ex_dest)       return 2'd2;
    else if (src != '0 && src == mem_dest) return 2'd1;
    else                                   return 2'd0;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> control unit bundle. Datapath is master, control unit is slave.
// fwd_a/fwd_b exist only when PIPE_CTRL_FORWARD_EN is defined.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [OPCODE_W-1:0]   id_opcode;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_zero;
  logic                  mem_ready;
  logic                  ex_alu_src;
  logic                  ex_reg_dst;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic                  mem_read;
  logic                  mem_write;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] wb_waddr;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  illegal_op;
`ifdef PIPE_CTRL_FORWARD_EN
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
`endif

  // No valid/ready pair: mem_ready qualifies an outstanding MEM-stage access;
  // while it is low with mem_read/mem_write high the whole pipeline holds.
  modport master (
`ifdef PIPE_CTRL_FORWARD_EN
    input  fwd_a, fwd_b,
`endif
    output id_opcode, id_rs, id_rt, id_rd, ex_zero, mem_ready,
    input  ex_alu_src, ex_reg_dst, ex_alu_op, mem_read, mem_write,
    input  wb_reg_write, wb_mem_to_reg, wb_waddr,
    input  pc_write, ifid_write, ifid_flush, illegal_op
  );

  modport slave (
`ifdef PIPE_CTRL_FORWARD_EN
    output fwd_a, fwd_b,
`endif
    input  id_opcode, id_rs, id_rt, id_rd, ex_zero, mem_ready,
    output ex_alu_src, ex_reg_dst, ex_alu_op, mem_read, mem_write,
    output wb_reg_write, wb_mem_to_reg, wb_waddr,
    output pc_write, ifid_write, ifid_flush, illegal_op
  );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage opcode decoder: produces the control bundle and an illegal flag.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_bundle_t        ctrl_o,
  output logic                illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o[CB_REG_DST]                = 1'b1;
        ctrl_o[CB_ALU_OP +: ALUOP_W]      = ALUOP_FUNCT;
        ctrl_o[CB_REG_WRITE]              = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o[CB_BRANCH]                 = 1'b1;
        ctrl_o[CB_ALU_OP +: ALUOP_W]      = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_o[CB_BRANCH]                 = 1'b1;
        ctrl_o[CB_BRANCH_NE]              = 1'b1;
        ctrl_o[CB_ALU_OP +: ALUOP_W]      = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_o[CB_ALU_SRC]                = 1'b1;
        ctrl_o[CB_ALU_OP +: ALUOP_W]      = ALUOP_ADD;
        ctrl_o[CB_REG_WRITE]              = 1'b1;
      end
      OP_LW, OP_LH, OP_LHU: begin
        ctrl_o[CB_MEM_READ]               = 1'b1;
        ctrl_o[CB_MEM_TO_REG]             = 1'b1;
        ctrl_o[CB_ALU_SRC]                = 1'b1;
        ctrl_o[CB_REG_WRITE]              = 1'b1;
      end
      OP_SW: begin
        ctrl_o[CB_MEM_WRITE]              = 1'b1;
        ctrl_o[CB_ALU_SRC]                = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, hazard/flush/stall.
// PIPE_CTRL_FORWARD_EN adds registered fwd_a/fwd_b and limits stalls to load-use.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  ctrl_bundle_t id_ctrl;
  logic         id_illegal;
  reg_addr_t    id_dest;

  pipe_ctrl_decode u_decode (
    .opcode_i  (bus.id_opcode),
    .ctrl_o    (id_ctrl),
    .illegal_o (id_illegal)
  );

  assign id_dest = !id_ctrl[CB_REG_WRITE] ? '0
                 : (id_ctrl[CB_REG_DST] ? bus.id_rd : bus.id_rt);

  ctrl_bundle_t idex_ctrl_q,        idex_ctrl_d;
  reg_addr_t    idex_dest_q,        idex_dest_d;
  logic         idex_illegal_q,     idex_illegal_d;
  logic         exmem_mem_read_q,   exmem_mem_read_d;
  logic         exmem_mem_write_q,  exmem_mem_write_d;
  logic         exmem_reg_write_q,  exmem_reg_write_d;
  logic         exmem_mem_to_reg_q, exmem_mem_to_reg_d;
  reg_addr_t    exmem_dest_q,       exmem_dest_d;
  logic         memwb_reg_write_q,  memwb_reg_write_d;
  logic         memwb_mem_to_reg_q, memwb_mem_to_reg_d;
  reg_addr_t    memwb_dest_q,       memwb_dest_d;

  logic        mem_stall, taken, load_use, hazard;
  pipe_event_t ev;

  assign mem_stall = (exmem_mem_read_q | exmem_mem_write_q) & ~bus.mem_ready;
  assign taken     = idex_ctrl_q[CB_BRANCH] & (bus.ex_zero ^ idex_ctrl_q[CB_BRANCH_NE]);
  assign load_use  = idex_ctrl_q[CB_MEM_READ] & reg_match(idex_dest_q, bus.id_rs, bus.id_rt);

`ifdef PIPE_CTRL_FORWARD_EN
  assign hazard = load_use;
`else
  // Without bypass paths any in-flight writer in EX or MEM blocks the reader;
  // WB is safe because the register file writes before it reads.
  assign hazard = load_use
                | reg_match(idex_dest_q,  bus.id_rs, bus.id_rt)
                | reg_match(exmem_dest_q, bus.id_rs, bus.id_rt);
`endif

  always_comb begin
    ev = EV_RUN;
    if (mem_stall)   ev = EV_MEM_STALL;
    else if (taken)  ev = EV_FLUSH;
    else if (hazard) ev = EV_HAZARD;
  end

  always_comb begin
    idex_ctrl_d        = id_ctrl;
    idex_dest_d        = id_dest;
    idex_illegal_d     = id_illegal;
    exmem_mem_read_d   = idex_ctrl_q[CB_MEM_READ];
    exmem_mem_write_d  = idex_ctrl_q[CB_MEM_WRITE];
    exmem_reg_write_d  = idex_ctrl_q[CB_REG_WRITE];
    exmem_mem_to_reg_d = idex_ctrl_q[CB_MEM_TO_REG];
    exmem_dest_d       = idex_dest_q;
    memwb_reg_write_d  = exmem_reg_write_q;
    memwb_mem_to_reg_d = exmem_mem_to_reg_q;
    memwb_dest_d       = exmem_dest_q;
    bus.pc_write       = 1'b1;
    bus.ifid_write     = 1'b1;
    bus.ifid_flush     = 1'b0;
    case (ev)
      EV_MEM_STALL: begin
        idex_ctrl_d        = idex_ctrl_q;
        idex_dest_d        = idex_dest_q;
        idex_illegal_d     = idex_illegal_q;
        exmem_mem_read_d   = exmem_mem_read_q;
        exmem_mem_write_d  = exmem_mem_write_q;
        exmem_reg_write_d  = exmem_reg_write_q;
        exmem_mem_to_reg_d = exmem_mem_to_reg_q;
        exmem_dest_d       = exmem_dest_q;
        memwb_reg_write_d  = memwb_reg_write_q;
        memwb_mem_to_reg_d = memwb_mem_to_reg_q;
        memwb_dest_d       = memwb_dest_q;
        bus.pc_write       = 1'b0;
        bus.ifid_write     = 1'b0;
      end
      EV_FLUSH: begin
        idex_ctrl_d    = '0;
        idex_dest_d    = '0;
        idex_illegal_d = 1'b0;
        bus.ifid_flush = 1'b1;
      end
      EV_HAZARD: begin
        idex_ctrl_d    = '0;
        idex_dest_d    = '0;
        idex_illegal_d = 1'b0;
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q        <= '0;
      idex_dest_q        <= '0;
      idex_illegal_q     <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_dest_q       <= '0;
      memwb_reg_write_q  <= 1'b0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_dest_q       <= '0;
    end else begin
      idex_ctrl_q        <= idex_ctrl_d;
      idex_dest_q        <= idex_dest_d;
      idex_illegal_q     <= idex_illegal_d;
      exmem_mem_read_q   <= exmem_mem_read_d;
      exmem_mem_write_q  <= exmem_mem_write_d;
      exmem_reg_write_q  <= exmem_reg_write_d;
      exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
      exmem_dest_q       <= exmem_dest_d;
      memwb_reg_write_q  <= memwb_reg_write_d;
      memwb_mem_to_reg_q <= memwb_mem_to_reg_d;
      memwb_dest_q       <= memwb_dest_d;
    end
  end

`ifdef PIPE_CTRL_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Selected in ID against the writers that will sit in EX/MEM and MEM/WB next cycle.
  always_comb begin
    fwd_a_d = fwd_sel(bus.id_rs, idex_dest_q, exmem_dest_q);
    fwd_b_d = fwd_sel(bus.id_rt, idex_dest_q, exmem_dest_q);
    case (ev)
      EV_MEM_STALL: begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
      end
      EV_FLUSH, EV_HAZARD: begin
        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;
`endif

  assign bus.ex_alu_src    = idex_ctrl_q[CB_ALU_SRC];
  assign bus.ex_reg_dst    = idex_ctrl_q[CB_REG_DST];
  assign bus.ex_alu_op     = idex_ctrl_q[CB_ALU_OP +: ALUOP_W];
  assign bus.mem_read      = exmem_mem_read_q;
  assign bus.mem_write     = exmem_mem_write_q;
  assign bus.wb_reg_write  = memwb_reg_write_q;
  assign bus.wb_mem_to_reg = memwb_mem_to_reg_q;
  assign bus.wb_waddr      = memwb_dest_q;
  assign bus.illegal_op    = idex_illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; expectations follow the default build unless
// PIPE_CTRL_FORWARD_EN is defined, in which case forwarding expectations apply.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_pkg::*;

  localparam int OBS_W = 17;
  localparam logic [5:0] OP_BAD = 6'h3F;

  logic clk;
  logic rst_n;
  pipe_ctrl_if bus ();

  pipe_ctrl_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [OBS_W-1:0] exp_q[$];
  int compared;
  int mismatched;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [OBS_W-1:0] ov(input logic src, input logic rdst,
      input logic [1:0] aop, input logic mr, input logic mw, input logic rw,
      input logic m2r, input logic [4:0] wa, input logic pcw, input logic ifw,
      input logic fl, input logic ill);
    return {src, rdst, aop, mr, mw, rw, m2r, wa, pcw, ifw, fl, ill};
  endfunction

  function automatic logic [OBS_W-1:0] observed();
    return {bus.ex_alu_src, bus.ex_reg_dst, bus.ex_alu_op, bus.mem_read, bus.mem_write,
            bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_waddr, bus.pc_write,
            bus.ifid_write, bus.ifid_flush, bus.illegal_op};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic zero, input logic ready);
    bus.id_opcode = op;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_rd     = rd;
    bus.ex_zero   = zero;
    bus.mem_ready = ready;
  endtask

  // One cycle: drive ID inputs, queue the expectation, compare mid-cycle, advance.
  task automatic cyc(input string tag, input logic [5:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic zero,
                     input logic ready, input logic [OBS_W-1:0] e);
    logic [OBS_W-1:0] got;
    logic [OBS_W-1:0] want;
    drive(op, rs, rt, rd, zero, ready);
    exp_q.push_back(e);
    @(negedge clk);
    got  = observed();
    want = exp_q.pop_front();
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef PIPE_CTRL_FORWARD_EN
  task automatic check_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    compared++;
    assert ({bus.fwd_a, bus.fwd_b} === {ea, eb}) else begin
      mismatched++;
      $error("FAIL %s: observed fwd=%b/%b expected fwd=%b/%b", tag, bus.fwd_a, bus.fwd_b,
             ea, eb);
    end
  endtask
`endif

  task automatic do_reset();
    rst_n = 1'b0;
    drive(OP_RTYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [OBS_W-1:0] v_rst;
    logic [OBS_W-1:0] v_nop_ex;
    compared   = 0;
    mismatched = 0;
    v_rst      = ov(0, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
    v_nop_ex   = ov(0, 1, 2'd2, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0);

    rst_n = 1'b0;
    drive(OP_RTYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_state", OP_RTYPE, 0, 0, 0, 0, 1, v_rst);
    rst_n = 1'b1;

    // R-type latency through EX, MEM, WB, then asynchronous reset mid-stream
    cyc("t1_issue",   OP_RTYPE, 1, 2, 3, 0, 1, v_rst);
    cyc("t1_ex",      OP_RTYPE, 0, 0, 0, 0, 1, v_nop_ex);
    cyc("t1_mem",     OP_RTYPE, 0, 0, 0, 0, 1, v_nop_ex);
    cyc("t1_wb",      OP_RTYPE, 0, 0, 0, 0, 1, ov(0, 1, 2'd2, 0, 0, 1, 0, 5'd3, 1, 1, 0, 0));
    rst_n = 1'b0;
    cyc("t1_async_reset", OP_RTYPE, 0, 0, 0, 0, 1, v_rst);
    rst_n = 1'b1;

    // lw $8 followed by a dependent add
    do_reset();
    cyc("t2_lw_id",    OP_LW,    9, 8, 0, 0, 1, v_rst);
    cyc("t2_load_use", OP_RTYPE, 8, 10, 11, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
`ifdef PIPE_CTRL_FORWARD_EN
    cyc("t2_bubble",   OP_RTYPE, 8, 10, 11, 0, 1, ov(0, 0, 2'd0, 1, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    check_fwd("t2_fwd", 2'd1, 2'd0);
    cyc("t2_add_ex",   OP_RTYPE, 0, 0, 0, 0, 1, ov(0, 1, 2'd2, 0, 0, 1, 1, 5'd8, 1, 1, 0, 0));
`else
    cyc("t2_raw_mem",  OP_RTYPE, 8, 10, 11, 0, 1, ov(0, 0, 2'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    cyc("t2_release",  OP_RTYPE, 8, 10, 11, 0, 1, ov(0, 0, 2'd0, 0, 0, 1, 1, 5'd8, 1, 1, 0, 0));
    cyc("t2_add_ex",   OP_RTYPE, 0, 0, 0, 0, 1, v_nop_ex);
`endif

    // beq taken in EX overrides a hazard on the instruction in ID
    do_reset();
    cyc("t3_lw_id",    OP_LW,    9, 8, 0, 0, 1, v_rst);
    cyc("t3_beq_id",   OP_BEQ,   1, 2, 0, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    cyc("t3_taken",    OP_RTYPE, 8, 10, 11, 1, 1, ov(0, 0, 2'd1, 1, 0, 0, 0, 5'd0, 1, 1, 1, 0));
    cyc("t3_bubble",   OP_RTYPE, 0, 0, 0, 0, 1, ov(0, 0, 2'd0, 0, 0, 1, 1, 5'd8, 1, 1, 0, 0));

    // bne with zero=1 falls through; bne with zero=0 flushes
    do_reset();
    cyc("t4_bne_id",     OP_BNE,  1, 2, 0, 0, 1, v_rst);
    cyc("t4_not_taken",  OP_ADDI, 0, 4, 0, 1, 1, ov(0, 0, 2'd1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    cyc("t4_advance",    OP_BNE,  1, 2, 0, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    cyc("t4_bne_taken",  OP_RTYPE, 0, 0, 0, 0, 1, ov(0, 0, 2'd1, 0, 0, 0, 0, 5'd0, 1, 1, 1, 0));

    // slow load in MEM freezes a taken beq in EX until mem_ready
    do_reset();
    cyc("t5_lw_id",      OP_LW,    9, 8, 0, 0, 1, v_rst);
    cyc("t5_beq_id",     OP_BEQ,   1, 2, 0, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc("t5_mem_stall", OP_RTYPE, 3, 4, 5, 1, 0, ov(0, 0, 2'd1, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    cyc("t5_flush",      OP_RTYPE, 3, 4, 5, 1, 1, ov(0, 0, 2'd1, 1, 0, 0, 0, 5'd0, 1, 1, 1, 0));
    cyc("t5_after",      OP_RTYPE, 0, 0, 0, 0, 1, ov(0, 0, 2'd0, 0, 0, 1, 1, 5'd8, 1, 1, 0, 0));

    // illegal opcode pulse, then addi $5 -> add rs=5
    do_reset();
    cyc("t6_illegal_id", OP_BAD,  0, 0, 0, 0, 1, v_rst);
    cyc("t6_illegal_ex", OP_ADDI, 0, 5, 0, 0, 1, ov(0, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 1));
`ifdef PIPE_CTRL_FORWARD_EN
    cyc("t6_no_stall",   OP_RTYPE, 5, 6, 7, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    check_fwd("t6_fwd", 2'd2, 2'd0);
    cyc("t6_add_ex",     OP_RTYPE, 0, 0, 0, 0, 1, v_nop_ex);
`else
    cyc("t6_raw_ex",     OP_RTYPE, 5, 6, 7, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    cyc("t6_raw_mem",    OP_RTYPE, 5, 6, 7, 0, 1, ov(0, 0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
    cyc("t6_release",    OP_RTYPE, 5, 6, 7, 0, 1, ov(0, 0, 2'd0, 0, 0, 1, 0, 5'd5, 1, 1, 0, 0));
    cyc("t6_add_ex",     OP_RTYPE, 0, 0, 0, 0, 1, v_nop_ex);
`endif

    // illegal_op held steady through a store's memory stall
    do_reset();
    cyc("t7_sw_id",      OP_SW,    1, 2, 0, 0, 1, v_rst);
    cyc("t7_sw_ex",      OP_BAD,   0, 0, 0, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    for (int i = 0; i < 2; i++)
      cyc("t7_ill_held", OP_RTYPE, 0, 0, 0, 0, 0, ov(0, 0, 2'd0, 0, 1, 0, 0, 5'd0, 0, 0, 0, 1));
    cyc("t7_release",    OP_RTYPE, 0, 0, 0, 0, 1, ov(0, 0, 2'd0, 0, 1, 0, 0, 5'd0, 1, 1, 0, 1));
    cyc("t7_no_repulse", OP_RTYPE, 0, 0, 0, 0, 1, v_nop_ex);

    // halfword loads decode like lw
    do_reset();
    cyc("t8_lh_id",      OP_LH,    0, 12, 0, 0, 1, v_rst);
    cyc("t8_lh_ex",      OP_LHU,   0, 13, 0, 0, 1, ov(1, 0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    cyc("t8_lhu_ex",     OP_RTYPE, 0, 0, 0, 0, 1, ov(1, 0, 2'd0, 1, 0, 0, 0, 5'd0, 1, 1, 0, 0));
    cyc("t8_lh_wb",      OP_RTYPE, 0, 0, 0, 0, 1, ov(0, 1, 2'd2, 1, 0, 1, 1, 5'd12, 1, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
